// File: rtl/ds_issue_ctrl.sv
// Decode-stage issue controller: DS pipeline register, per-source operand bypass
// network and per-register scoreboard for out-of-band long-latency writebacks.
module ds_issue_ctrl #(
   parameter int XLEN = 32,
   parameter int AW   = 5,
   parameter int NSRC = 2,
   parameter int NFWD = 3,
   parameter int PW   = 64,
   parameter int CW   = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_allowin,
   input  logic [PW-1:0]        in_payload,
   input  logic [NSRC*AW-1:0]   in_src,
   input  logic [NSRC-1:0]      in_need,
   input  logic                 in_rf_we,
   input  logic [AW-1:0]        in_dest,
   input  logic                 in_long,
   input  logic                 flush,
   output logic [NSRC*AW-1:0]   rf_raddr,
   input  logic [NSRC*XLEN-1:0] rf_rdata,
   input  logic [NFWD-1:0]      fwd_we,
   input  logic [NFWD*AW-1:0]   fwd_waddr,
   input  logic [NFWD*XLEN-1:0] fwd_wdata,
   input  logic [NFWD-1:0]      fwd_rdy,
   input  logic                 lg_done,
   input  logic [AW-1:0]        lg_waddr,
   output logic                 out_valid,
   input  logic                 out_allowin,
   output logic [PW-1:0]        out_payload,
   output logic [NSRC*XLEN-1:0] out_opnd,
   output logic                 out_rf_we,
   output logic [AW-1:0]        out_dest,
   output logic                 out_long,
   output logic                 stall,
   output logic                 sb_err
);

   localparam int NREG = 1 << AW;
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic                ds_valid_reg;
   logic [PW-1:0]       payload_reg;
   logic [NSRC*AW-1:0]  src_reg;
   logic [NSRC-1:0]     need_reg;
   logic                rf_we_reg;
   logic [AW-1:0]       dest_reg;
   logic                long_reg;
   logic                sb_err_reg;

   logic [CW-1:0]       cnt_all [NREG];
   logic [NSRC-1:0]     src_stall;
   logic                waw_stall;
   logic                sat_stall;
   logic                ready_go;
   logic                load;
   logic                sb_inc;
   logic                sb_dec;
   logic                dec_underflow;

   // ------------------------------------------------------------------
   // DS pipeline register
   // ------------------------------------------------------------------
   assign load = in_valid & in_allowin & ~flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ds_valid_reg <= 1'b0;
         payload_reg  <= '0;
         src_reg      <= '0;
         need_reg     <= '0;
         rf_we_reg    <= 1'b0;
         dest_reg     <= '0;
         long_reg     <= 1'b0;
      end else begin
         if (flush)
            ds_valid_reg <= 1'b0;
         else if (in_allowin)
            ds_valid_reg <= in_valid;
         if (load) begin
            payload_reg <= in_payload;
            src_reg     <= in_src;
            need_reg    <= in_need;
            rf_we_reg   <= in_rf_we;
            dest_reg    <= in_dest;
            long_reg    <= in_long;
         end
      end
   end

   assign rf_raddr    = src_reg;
   assign out_payload = payload_reg;
   assign out_rf_we   = rf_we_reg;
   assign out_dest    = dest_reg;
   assign out_long    = long_reg;

   // ------------------------------------------------------------------
   // Bypass network: youngest matching stage wins, r0 always reads zero
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_src
         logic [AW-1:0]   src;
         logic [XLEN-1:0] opnd;
         logic            hit_rdy;

         assign src = src_reg[gi*AW +: AW];

         always_comb begin
            opnd    = rf_rdata[gi*XLEN +: XLEN];
            hit_rdy = 1'b1;
            // Walk oldest to youngest so the youngest match is left standing.
            for (int j = NFWD - 1; j >= 0; j--) begin
               if (fwd_we[j] && (fwd_waddr[j*AW +: AW] == src)) begin
                  opnd    = fwd_wdata[j*XLEN +: XLEN];
                  hit_rdy = fwd_rdy[j];
               end
            end
            if (src == '0) begin
               opnd    = '0;
               hit_rdy = 1'b1;
            end
         end

         assign src_stall[gi] = need_reg[gi] & (~hit_rdy | (cnt_all[src] != '0));
         assign out_opnd[gi*XLEN +: XLEN] = opnd;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Issue control
   // ------------------------------------------------------------------
   assign waw_stall = rf_we_reg & (dest_reg != '0) & (cnt_all[dest_reg] != '0) & ~long_reg;
   assign sat_stall = long_reg & rf_we_reg & (cnt_all[dest_reg] == CNT_MAX);
   assign ready_go  = ~(|src_stall | waw_stall | sat_stall);

   assign out_valid  = ds_valid_reg & ready_go;
   assign in_allowin = ~ds_valid_reg | (ready_go & out_allowin);
   assign stall      = ds_valid_reg & ~ready_go;

   // ------------------------------------------------------------------
   // Scoreboard: one saturating-by-construction counter per register
   // ------------------------------------------------------------------
   assign sb_inc = out_valid & out_allowin & out_long & out_rf_we & (out_dest != '0);
   assign sb_dec = lg_done & (lg_waddr != '0);

   assign cnt_all[0] = '0;

   generate
      for (gi = 1; gi < NREG; gi++) begin : g_reg
         logic [CW-1:0] cnt_reg;
         logic          inc_hit;
         logic          dec_hit;

         assign inc_hit = sb_inc & (out_dest == AW'(gi));
         assign dec_hit = sb_dec & (lg_waddr == AW'(gi));

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)
               cnt_reg <= '0;
            else if (inc_hit && !dec_hit)
               cnt_reg <= cnt_reg + CW'(1);
            else if (dec_hit && !inc_hit && (cnt_reg != '0))
               cnt_reg <= cnt_reg - CW'(1);
         end

         assign cnt_all[gi] = cnt_reg;
      end
   endgenerate

   // A same-cycle issue to the released register absorbs the writeback,
   // so that case is not an underflow.
   assign dec_underflow = sb_dec & (cnt_all[lg_waddr] == '0)
                        & ~(sb_inc & (out_dest == lg_waddr));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         sb_err_reg <= 1'b0;
      else if (dec_underflow)
         sb_err_reg <= 1'b1;
   end

   assign sb_err = sb_err_reg;

endmodule
